// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-approach traffic controller:
// phase encoding, light codes and the 7-segment digit table.
package traffic_pkg;

   typedef enum logic [2:0] {
      A_GREEN,
      A_YELLOW,
      B_GREEN,
      B_YELLOW,
      FLASH
   } phase_t;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam int         MAX_DIGITS = 8;

   // Active-low segments, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] segLut(input logic [3:0] digit);
      logic [6:0] segs;
      case (digit)
         4'd0:    segs = 7'h40;
         4'd1:    segs = 7'h79;
         4'd2:    segs = 7'h24;
         4'd3:    segs = 7'h30;
         4'd4:    segs = 7'h19;
         4'd5:    segs = 7'h12;
         4'd6:    segs = 7'h02;
         4'd7:    segs = 7'h78;
         4'd8:    segs = 7'h00;
         4'd9:    segs = 7'h10;
         default: segs = SEG_BLANK;
      endcase
      return segs;
   endfunction

   // Elaboration-time encoding of a constant, used for the reset image of the displays
   function automatic logic [7*MAX_DIGITS-1:0] segConst(input int value, input int digits,
                                                        input int lzBlank);
      logic [7*MAX_DIGITS-1:0] segs;
      int                      rem;
      segs = '1;
      rem  = value;
      for (int d = 0; d < MAX_DIGITS; d++) begin
         if (d < digits) begin
            if (d == 0 || rem != 0 || lzBlank == 0) begin
               segs[7*d +: 7] = segLut(4'(rem % 10));
            end
            rem = rem / 10;
         end
      end
      return segs;
   endfunction

endpackage

// File: rtl/seg_digits.sv
// Binary value to packed active-low 7-segment digits via combinational
// double-dabble, with optional leading-zero blanking and a whole-display blank.
module seg_digits
   import traffic_pkg::*;
#(
   parameter int DIGITS   = 2,
   parameter int LZ_BLANK = 1,
   parameter int W        = 5
) (
   input  logic [W-1:0]        i_value,
   input  logic                i_blank,
   output logic [7*DIGITS-1:0] o_segs
);

   logic [4*DIGITS-1:0] w_bcd;

   always_comb begin
      w_bcd = '0;
      for (int i = W - 1; i >= 0; i--) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (w_bcd[4*d +: 4] >= 4'd5) begin
               w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
            end
         end
         w_bcd = {w_bcd[4*DIGITS-2:0], i_value[i]};
      end
   end

   // Walk from the most significant digit; a digit is blanked while everything above it is zero
   always_comb begin
      logic leadZero;
      leadZero = 1'b1;
      o_segs   = '1;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         leadZero = leadZero && (w_bcd[4*d +: 4] == 4'd0);
         if (i_blank) begin
            o_segs[7*d +: 7] = SEG_BLANK;
         end else if (LZ_BLANK != 0 && d != 0 && leadZero) begin
            o_segs[7*d +: 7] = SEG_BLANK;
         end else begin
            o_segs[7*d +: 7] = segLut(w_bcd[4*d +: 4]);
         end
      end
   end

endmodule

// File: rtl/traffic_countdown_disp.sv
// Two-approach traffic light controller with per-approach countdown displays,
// driven from one prescaler and one phase timer so both sides stay in step.
module traffic_countdown_disp
   import traffic_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int GREEN_T  = 25,
   parameter int YELLOW_T = 5,
   parameter int DIGITS   = 2,
   parameter int LZ_BLANK = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flash_en,
   input  logic                hold,
   output logic [2:0]          light_a,
   output logic [2:0]          light_b,
   output logic [7*DIGITS-1:0] hex_a,
   output logic [7*DIGITS-1:0] hex_b,
   output logic                tick
);

   localparam int PW    = $clog2(GREEN_T + YELLOW_T + 1);
   localparam int PRE_W = $clog2(TICK_DIV);

   localparam logic [PW-1:0]    GREEN_LD  = PW'(GREEN_T);
   localparam logic [PW-1:0]    YELLOW_LD = PW'(YELLOW_T);
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);

   localparam logic [7*MAX_DIGITS-1:0] RST_SEGS_A = segConst(GREEN_T, DIGITS, LZ_BLANK);
   localparam logic [7*MAX_DIGITS-1:0] RST_SEGS_B = segConst(GREEN_T + YELLOW_T, DIGITS, LZ_BLANK);

   if (TICK_DIV < 2 || GREEN_T < 1 || YELLOW_T < 1 || DIGITS < 1 || DIGITS > MAX_DIGITS ||
       GREEN_T + YELLOW_T > 10**DIGITS - 1) begin : g_paramCheck
      $error("traffic_countdown_disp: parameters out of range");
   end

   phase_t               r_state;
   phase_t               w_nextState;
   logic [PW-1:0]        r_ptim;
   logic [PW-1:0]        w_nextPtim;
   logic                 r_blink;
   logic                 w_nextBlink;
   logic [PRE_W-1:0]     r_pre;
   logic                 r_tick;
   logic                 w_leaveFlash;

   logic [2:0]           w_lightA;
   logic [2:0]           w_lightB;
   logic [PW-1:0]        w_valA;
   logic [PW-1:0]        w_valB;
   logic                 w_blankDisp;
   logic [7*DIGITS-1:0]  w_segsA;
   logic [7*DIGITS-1:0]  w_segsB;
   logic [2:0]           r_lightA;
   logic [2:0]           r_lightB;
   logic [7*DIGITS-1:0]  r_hexA;
   logic [7*DIGITS-1:0]  r_hexB;

   assign w_leaveFlash = (r_state == FLASH) && !flash_en;

   // Leaving night mode restarts the tick period so the first green second is full length
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
      end else if (w_leaveFlash) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
      end else if (hold) begin
         r_tick <= 1'b0;
      end else if (r_pre == PRE_LAST) begin
         r_pre  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_pre  <= r_pre + PRE_W'(1);
         r_tick <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= A_GREEN;
         r_ptim  <= GREEN_LD;
         r_blink <= 1'b1;
      end else begin
         r_state <= w_nextState;
         r_ptim  <= w_nextPtim;
         r_blink <= w_nextBlink;
      end
   end

   // A pending tick is honoured even if hold rises with it, since hold only stops the prescaler
   always_comb begin
      w_nextState = r_state;
      w_nextPtim  = r_ptim;
      w_nextBlink = r_blink;
      if (flash_en) begin
         w_nextState = FLASH;
         if (r_tick) begin
            w_nextBlink = ~r_blink;
         end
      end else if (r_state == FLASH) begin
         w_nextState = A_GREEN;
         w_nextPtim  = GREEN_LD;
         w_nextBlink = 1'b1;
      end else if (r_tick) begin
         if (r_ptim == PW'(1)) begin
            case (r_state)
               A_GREEN: begin
                  w_nextState = A_YELLOW;
                  w_nextPtim  = YELLOW_LD;
               end
               A_YELLOW: begin
                  w_nextState = B_GREEN;
                  w_nextPtim  = GREEN_LD;
               end
               B_GREEN: begin
                  w_nextState = B_YELLOW;
                  w_nextPtim  = YELLOW_LD;
               end
               default: begin
                  w_nextState = A_GREEN;
                  w_nextPtim  = GREEN_LD;
               end
            endcase
         end else begin
            w_nextPtim = r_ptim - PW'(1);
         end
      end
   end

   // Decoded from the next-state values so lights and displays land on the same edge as the state
   always_comb begin
      w_lightA    = RED;
      w_lightB    = RED;
      w_valA      = w_nextPtim;
      w_valB      = w_nextPtim;
      w_blankDisp = 1'b0;
      case (w_nextState)
         A_GREEN: begin
            w_lightA = GRN;
            w_valB   = w_nextPtim + YELLOW_LD;
         end
         A_YELLOW: begin
            w_lightA = YEL;
         end
         B_GREEN: begin
            w_lightB = GRN;
            w_valA   = w_nextPtim + YELLOW_LD;
         end
         B_YELLOW: begin
            w_lightB = YEL;
         end
         default: begin
            w_lightA    = w_nextBlink ? YEL : OFF;
            w_lightB    = w_nextBlink ? YEL : OFF;
            w_blankDisp = 1'b1;
         end
      endcase
   end

   seg_digits #(
      .DIGITS   (DIGITS),
      .LZ_BLANK (LZ_BLANK),
      .W        (PW)
   ) u_segA (
      .i_value (w_valA),
      .i_blank (w_blankDisp),
      .o_segs  (w_segsA)
   );

   seg_digits #(
      .DIGITS   (DIGITS),
      .LZ_BLANK (LZ_BLANK),
      .W        (PW)
   ) u_segB (
      .i_value (w_valB),
      .i_blank (w_blankDisp),
      .o_segs  (w_segsB)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lightA <= GRN;
         r_lightB <= RED;
         r_hexA   <= RST_SEGS_A[7*DIGITS-1:0];
         r_hexB   <= RST_SEGS_B[7*DIGITS-1:0];
      end else begin
         r_lightA <= w_lightA;
         r_lightB <= w_lightB;
         r_hexA   <= w_segsA;
         r_hexB   <= w_segsB;
      end
   end

   assign light_a = r_lightA;
   assign light_b = r_lightB;
   assign hex_a   = r_hexA;
   assign hex_b   = r_hexB;
   assign tick    = r_tick;

endmodule

// File: doc/traffic_countdown_disp.md
# traffic_countdown_disp

Two-approach traffic-light controller with per-approach countdown displays. It owns the phase timer and the one-second tick, so the two sides' times are derived from a single counter and cannot drift apart. Phase durations, tick rate and digit count are parameters. Adds flashing-yellow night mode, a countdown hold, and leading-zero blanking. Sits between the board clock and the HEX displays / light drivers at top level.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per countdown tick (≥2)
- `GREEN_T`, default 25: green duration in ticks (≥1)
- `YELLOW_T`, default 5: yellow duration in ticks (≥1)
- `DIGITS`, default 2: decimal digits per side; GREEN_T+YELLOW_T ≤ 10^DIGITS−1 (elaboration check)
- `LZ_BLANK`, default 1: 1 = blank leading zeros (never the units digit)
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous active-low reset
- `flash_en` in 1: level; night mode
- `hold` in 1: level; freezes prescaler and phase timer
- `light_a` out 3: approach A {red,yellow,green}, one-hot, active-high
- `light_b` out 3: approach B, same encoding
- `hex_a` out 7*DIGITS: approach A segments, active-low, digit 0 = units in bits [6:0]
- `hex_b` out 7*DIGITS: approach B segments
- `tick` out 1: one-cycle pulse per countdown tick

## Operation
- FSM states: A_GREEN, A_YELLOW, B_GREEN, B_YELLOW, FLASH.
- Cycle: A_GREEN → A_YELLOW → B_GREEN → B_YELLOW → A_GREEN.
- Phase timer `ptim` loads the new phase's duration on entry (GREEN_T or YELLOW_T) and decrements on each `tick`. When `tick` arrives with `ptim==1`, the FSM advances and reloads `ptim`; `ptim` never reaches 0.
- Lights:
  - A_GREEN: A=001, B=100.
  - A_YELLOW: A=010, B=100.
  - B states mirror A.
  - FLASH: both sides 010 when blink=1, 000 when blink=0.
- Displayed value:
  - Active (green/yellow) side shows `ptim`.
  - Red side shows `ptim + YELLOW_T` during the other side's green, and `ptim` during the other side's yellow.
  - Both values are computed from the single `ptim`.
- FLASH:
  - Entered the cycle after `flash_en` is sampled high, from any state.
  - Both hex outputs are all-ones (blank).
  - `blink` toggles on each `tick`.
  - On `flash_en` low, the next state is A_GREEN with `ptim`=GREEN_T, the prescaler cleared and `blink`=1.
- `hold` high:
  - Prescaler and `ptim` freeze; no `tick` pulses.
  - Lights and displays stay static.
  - `flash_en` still wins over `hold`; FLASH blink is also frozen while `hold` is high.
- Arithmetic:
  - `ptim` width is $clog2(GREEN_T+YELLOW_T+1).
  - Binary-to-BCD is combinational double-dabble over DIGITS digits.
  - Segment patterns are the standard 0–9 set.

## Timing
- Reset values (async assert, sync deassert handled at top level):
  - state=A_GREEN, `ptim`=GREEN_T, prescaler=0, blink=1, `tick`=0.
  - `light_a`=001, `light_b`=100.
  - `hex_a` shows GREEN_T, `hex_b` shows GREEN_T+YELLOW_T.
- `tick` rises TICK_DIV cycles after reset release, then every TICK_DIV cycles while `hold`=0.
- Lights, `hex_*` and state are registered and update in the cycle after `tick`; latency is 1 clk.
- Simultaneous `tick` and `flash_en` rise: FLASH is entered, the `tick` is consumed, and blink toggles.
- `hold` rising on the same cycle as `tick`: that `tick` still takes effect, then the block freezes.
- Reset mid-phase: immediate return to the reset values, with no glitch through other lights.
- Never both greens, and never green on one side with yellow on the other, in any cycle.

## Structure
- Package `traffic_pkg`:
  - phase enum (5 states);
  - light codes RED=3'b100, YEL=3'b010, GRN=3'b001, OFF=3'b000;
  - 7-seg digit LUT function;
  - SEG_BLANK=7'h7F.
- Sub-module `seg_digits` (parameters DIGITS, LZ_BLANK, input width): binary value + blank input → packed active-low segments.
  - Instantiated twice, once per approach.
  - Purely combinational; its output is registered in the parent.
- Parent holds: prescaler, FSM, `ptim`, blink and output registers.

## Test plan
All scenarios use TICK_DIV=4, GREEN_T=5, YELLOW_T=3, DIGITS=2, LZ_BLANK=1.
- Reset release → `light_a`=001, `light_b`=100; `hex_a`=" 5", `hex_b`=" 8"; first `tick` 4 clk later; displays then read 4 / 7.
- Free run 16 ticks → A shows 5,4,3,2,1 green, then 3,2,1 yellow; B shows 8…1 red; then B green 5 with A red 8. Full period is 16 ticks (64 clk).
- GREEN_T=12 → two-digit "12" with no blanking; at 9 the tens digit blanks (`hex_a[13:7]`=7'h7F).
- `flash_en` pulse high for 10 ticks mid A_YELLOW → both sides 010/000 alternating per tick, hex blank; on release, A_GREEN with `hex_a`=" 5" and next `tick` 4 clk later.
- `hold` high for 20 clk at `ptim`=2 → no `tick`, outputs unchanged; on release, the countdown resumes from 2 with the prescaler at its held value.
- `rst_n` low mid B_GREEN, checked asynchronously within the same cycle → reset values. Assertion over the whole run: never green+green, never green+yellow.
